bin2bcd_converter: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3) that sits directly upstream of the per-digit 7-segment decoders in the MPPC dark counter display path. It takes a binary count value on a start strobe and produces NUM_DIGITS packed BCD digits after a fixed latency. It flags values that do not fit the display by forcing every digit nibble to 4'hF, so each downstream decoder shows a minus sign.

---
 rtl/bin2bcd_converter.sv | 146 ++++++++++++++
 tb/tb_bin2bcd_converter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: sequential shift-and-add-3 binary to packed BCD converter.
// One SHIFT iteration per input bit, then a single DONE cycle publishes the
// result. Values above the display range show as all-0xF nibbles with OVF set.
module bin2bcd_converter #(
  parameter int BIN_WIDTH  = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BIN_WIDTH-1:0]    BIN,
  input  logic                    start,
  output logic [4*NUM_DIGITS-1:0] BCD,
  output logic                    busy,
  output logic                    done,
  output logic                    OVF
);

  localparam int SCR_W  = 4 * NUM_DIGITS;
  localparam int ITER_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  // Largest displayable value, 10^NUM_DIGITS - 1, evaluated at elaboration.
  function automatic logic [63:0] max_display(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int d = 0; d < digits; d++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LP_MAX = max_display(NUM_DIGITS);

  // Add 3 to every nibble that is 5 or more, so the following shift carries
  // correctly into the next decimal digit.
  function automatic logic [SCR_W-1:0] add3_nibbles(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = s[4*k +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [SCR_W-1:0]     r_scr;
  logic [ITER_W-1:0]    r_iter;
  logic                 r_ovf_pend;
  logic [SCR_W-1:0]     r_bcd;
  logic                 r_ovf;
  logic                 r_busy;
  logic                 r_done;

  logic [SCR_W-1:0]     w_adj;
  logic [SCR_W-1:0]     w_scr_next;
  logic [BIN_WIDTH-1:0] w_bin_next;
  logic                 w_ovf_cmp;

  // One iteration of the combined {scratch, binary} adjust-then-shift step,
  // plus the range check on the incoming value. When the display range
  // exceeds what BIN can hold, the comparison is constant false.
  always_comb begin
    w_adj      = add3_nibbles(r_scr);
    w_scr_next = {w_adj[SCR_W-2:0], r_bin[BIN_WIDTH-1]};
    w_bin_next = {r_bin[BIN_WIDTH-2:0], 1'b0};
    w_ovf_cmp  = (64'(BIN) > LP_MAX);
  end

  // Control FSM with datapath and registered outputs; busy trails the state by
  // one edge so it stays high through the cycle the result is published.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bin      <= {BIN_WIDTH{1'b0}};
      r_scr      <= {SCR_W{1'b0}};
      r_iter     <= {ITER_W{1'b0}};
      r_ovf_pend <= 1'b0;
      r_bcd      <= {SCR_W{1'b0}};
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_bin      <= BIN;
            r_scr      <= {SCR_W{1'b0}};
            r_iter     <= ITER_W'(BIN_WIDTH - 1);
            r_ovf_pend <= w_ovf_cmp;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end else begin
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_scr  <= w_scr_next;
          r_bin  <= w_bin_next;
          if (r_iter == {ITER_W{1'b0}}) begin
            r_state <= ST_DONE;
          end else begin
            r_iter  <= r_iter - ITER_W'(1);
            r_state <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b1;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
          if (r_ovf_pend) begin
            r_bcd <= {SCR_W{1'b1}};
            r_ovf <= 1'b1;
          end else begin
            r_bcd <= r_scr;
            r_ovf <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign BCD  = r_bcd;
  assign OVF  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// tb_bin2bcd_converter: directed and randomized checks of bin2bcd_converter
// against a decimal-arithmetic reference model.
module tb_bin2bcd_converter;

  logic        clk;
  logic        rst;
  logic [13:0] BIN;
  logic        start;
  logic [15:0] BCD;
  logic        busy;
  logic        done;
  logic        OVF;

  int n_assert;
  int n_fail;

  bin2bcd_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .BIN  (BIN),
    .start(start),
    .BCD  (BCD),
    .busy (busy),
    .done (done),
    .OVF  (OVF)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: decimal digits by division, or all-F when out of range.
  function automatic logic [15:0] model_bcd(input int v);
    logic [15:0] r;
    int x;
    if (v > 9999) return 16'hFFFF;
    r = 16'h0000;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    return (v > 9999);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion of v; optionally pulses start with ign_v on edge
  // T0+ign_at (0 disables) to show that it is ignored.
  task automatic convert(input int v, input int ign_at, input int ign_v);
    logic [15:0] prev;
    int cnt;
    int busy_n;
    int stable;
    prev = BCD;
    BIN = 14'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    BIN = 14'($urandom_range(0, 16383));
    check("busy_at_accept", {15'd0, busy}, 16'd1);
    cnt = 0;
    busy_n = 1;
    stable = 1;
    while (cnt < 40) begin
      if (ign_at != 0 && cnt + 1 == ign_at) begin
        start = 1'b1;
        BIN = 14'(ign_v);
      end
      tick();
      start = 1'b0;
      cnt++;
      busy_n += int'(busy);
      if (done) break;
      if (BCD !== prev) stable = 0;
    end
    check("done_latency", 16'(cnt), 16'd15);
    check("bcd_value", BCD, model_bcd(v));
    check("ovf_value", {15'd0, OVF}, {15'd0, model_ovf(v)});
    check("busy_cycles", 16'(busy_n), 16'd16);
    check("bcd_stable_until_done", 16'(stable), 16'd1);
    tick();
    check("busy_after", {15'd0, busy}, 16'd0);
    check("done_after", {15'd0, done}, 16'd0);
  endtask

  initial begin
    logic [15:0] hold;
    int extra;
    int q[$];
    int v;
    n_assert = 0;
    n_fail = 0;
    rst = 1'b1;
    start = 1'b0;
    BIN = 14'd0;
    tick();
    tick();
    check("rst_bcd", BCD, 16'h0000);
    check("rst_ovf", {15'd0, OVF}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    rst = 1'b0;
    tick();

    convert(0, 0, 0);
    convert(1234, 0, 0);
    hold = BCD;
    repeat (5) tick();
    check("bcd_hold_idle", BCD, hold);
    convert(9999, 0, 0);
    convert(10000, 0, 0);
    convert(16383, 0, 0);
    convert(7, 0, 0);

    // start during SHIFT is ignored and yields no second done
    convert(42, 5, 99);
    extra = 0;
    repeat (20) begin
      tick();
      extra += int'(done);
    end
    check("no_extra_done", 16'(extra), 16'd0);

    // reset in the middle of a conversion
    BIN = 14'd5000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_bcd", BCD, 16'h0000);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_done", {15'd0, done}, 16'd0);
    check("midrst_ovf", {15'd0, OVF}, 16'd0);
    extra = 0;
    repeat (20) begin
      tick();
      extra += int'(done);
    end
    check("midrst_no_done", 16'(extra), 16'd0);
    convert(5000, 0, 0);

    // reset and start on the same edge: reset wins
    rst = 1'b1;
    start = 1'b1;
    BIN = 14'd123;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {15'd0, busy}, 16'd0);
    tick();
    check("rst_start_idle", {15'd0, busy}, 16'd0);

    // held-high start with random BIN every cycle
    extra = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 16 * 8; cyc++) begin
      v = int'($urandom_range(0, 16383));
      if ((cyc % 4) == 0) v = int'($urandom_range(0, 9999));
      BIN = 14'(v);
      if ((cyc % 16) == 0) q.push_back(v);
      tick();
      if ((cyc % 16) == 15) begin
        v = q.pop_front();
        check("held_done", {15'd0, done}, 16'd1);
        check("held_bcd", BCD, model_bcd(v));
        check("held_ovf", {15'd0, OVF}, {15'd0, model_ovf(v)});
      end else begin
        extra += int'(done);
      end
    end
    start = 1'b0;
    check("held_no_stray_done", 16'(extra), 16'd0);
    repeat (20) tick();
    check("held_end_idle", {15'd0, busy}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
